// File: rtl/alu_uart_ctrl_module_if.sv
// rtl/alu_uart_ctrl_module_if.sv - UART/ALU handshake bundle for the frame controller
interface alu_uart_ctrl_module_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_data_A;
  logic [NB_DATA-1:0] o_alu_data_B;
  logic [NB_OP-1:0]   o_alu_OP;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_err;
  logic [7:0]         o_drop_cnt;

  // controller side
  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    output o_alu_data_A, o_alu_data_B, o_alu_OP, o_tx_data,
    output o_tx_start, o_busy, o_err, o_drop_cnt
  );

  // environment side (UART receiver/transmitter and ALU)
  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    input  o_alu_data_A, o_alu_data_B, o_alu_OP, o_tx_data,
    input  o_tx_start, o_busy, o_err, o_drop_cnt
  );
endinterface

// File: rtl/alu_uart_ctrl_module.sv
// rtl/alu_uart_ctrl_module.sv - collects A/B/OP bytes from UART, runs the ALU, sends the result
module alu_uart_ctrl_module #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  alu_uart_ctrl_module_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic [7:0]         drop_q, drop_d;
  logic               busy, err, tx_start;

  // Opcodes the attached ALU implements; anything else yields a zero result
  function automatic logic op_is_valid(input logic [NB_OP-1:0] op);
    logic [7:0] op8;
    op8 = 8'(op);
    case (op8)
      8'h20, 8'h22, 8'h24, 8'h25,
      8'h26, 8'h03, 8'h02, 8'h27: op_is_valid = 1'b1;
      default:                    op_is_valid = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state: three operand bytes, one exec cycle, one start cycle, wait for tx_done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_rx_done) state_d = WAIT_B;
      WAIT_B:  if (bus.i_rx_done) state_d = WAIT_OP;
      WAIT_OP: if (bus.i_rx_done) state_d = EXEC;
      EXEC:    state_d = SEND;
      // tx_done coinciding with tx_start belongs to an earlier byte, so it is ignored here
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (bus.i_tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    busy      = (state_q != IDLE);
    err       = (state_q == EXEC) && !op_is_valid(op_q);
    tx_start  = (state_q == SEND);
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE:    if (bus.i_rx_done) a_d  = bus.i_rx_data;
      WAIT_B:  if (bus.i_rx_done) b_d  = bus.i_rx_data;
      WAIT_OP: if (bus.i_rx_done) op_d = bus.i_rx_data[NB_OP-1:0];
      default: ;
    endcase
    if (state_q == EXEC) tx_data_d = bus.i_alu_result;
    // bytes arriving while a result is in flight are lost; count them, saturating
    if (bus.i_rx_done && (state_q == EXEC || state_q == SEND || state_q == WAIT_TX)
        && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      drop_q    <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.o_alu_data_A = a_q;
  assign bus.o_alu_data_B = b_q;
  assign bus.o_alu_OP     = op_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start;
  assign bus.o_busy       = busy;
  assign bus.o_err        = err;
  assign bus.o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_alu_uart_ctrl_module.sv
// tb/tb_alu_uart_ctrl_module.sv - directed bench for the UART/ALU frame controller
module tb_alu_uart_ctrl_module;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  alu_uart_ctrl_module_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_ctrl_module #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in
  always_comb begin
    bus.i_alu_result = 8'h00;
    case (bus.o_alu_OP)
      6'h20: bus.i_alu_result = bus.o_alu_data_A + bus.o_alu_data_B;
      6'h22: bus.i_alu_result = bus.o_alu_data_A - bus.o_alu_data_B;
      6'h24: bus.i_alu_result = bus.o_alu_data_A & bus.o_alu_data_B;
      6'h25: bus.i_alu_result = bus.o_alu_data_A | bus.o_alu_data_B;
      6'h26: bus.i_alu_result = bus.o_alu_data_A ^ bus.o_alu_data_B;
      6'h03: bus.i_alu_result = 8'($signed(bus.o_alu_data_A) >>> bus.o_alu_data_B);
      6'h02: bus.i_alu_result = bus.o_alu_data_A >> bus.o_alu_data_B;
      6'h27: bus.i_alu_result = ~(bus.o_alu_data_A | bus.o_alu_data_B);
      default: bus.i_alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_A"},    32'(bus.o_alu_data_A), 32'h0);
    chk({tag, "_B"},    32'(bus.o_alu_data_B), 32'h0);
    chk({tag, "_OP"},   32'(bus.o_alu_OP),     32'h0);
    chk({tag, "_txd"},  32'(bus.o_tx_data),    32'h0);
    chk({tag, "_txs"},  32'(bus.o_tx_start),   32'h0);
    chk({tag, "_busy"}, 32'(bus.o_busy),       32'h0);
    chk({tag, "_err"},  32'(bus.o_err),        32'h0);
    chk({tag, "_drop"}, 32'(bus.o_drop_cnt),   32'h0);
  endtask

  // Sends A, B, OP and checks up to the WAIT_TX state; caller finishes the transfer
  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [7:0] exp_tx, input logic exp_err);
    rx_byte(a);
    chk({tag, "_A"}, 32'(bus.o_alu_data_A), 32'(a));
    chk({tag, "_busyB"}, 32'(bus.o_busy), 32'h1);
    rx_byte(b);
    chk({tag, "_B"}, 32'(bus.o_alu_data_B), 32'(b));
    rx_byte(op);
    chk({tag, "_OP"}, 32'(bus.o_alu_OP), 32'(op & 8'h3F));
    chk({tag, "_exec_txs"}, 32'(bus.o_tx_start), 32'h0);
    chk({tag, "_exec_err"}, 32'(bus.o_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_send_txs"}, 32'(bus.o_tx_start), 32'h1);
    chk({tag, "_send_txd"}, 32'(bus.o_tx_data), 32'(exp_tx));
    chk({tag, "_send_err"}, 32'(bus.o_err), 32'h0);
    @(negedge clk);
    chk({tag, "_wtx_txs"}, 32'(bus.o_tx_start), 32'h0);
    chk({tag, "_wtx_busy"}, 32'(bus.o_busy), 32'h1);
  endtask

  task automatic finish_tx(input string tag, input logic [7:0] exp_tx);
    @(negedge clk);
    chk({tag, "_hold_busy"}, 32'(bus.o_busy), 32'h1);
    tx_done_pulse();
    chk({tag, "_idle_busy"}, 32'(bus.o_busy), 32'h0);
    chk({tag, "_idle_txd"}, 32'(bus.o_tx_data), 32'(exp_tx));
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;

    // ADD, with a tx_done coinciding with tx_start that must be ignored
    rx_byte(8'h05);
    rx_byte(8'h03);
    rx_byte(8'h20);
    chk("add_exec_err", 32'(bus.o_err), 32'h0);
    chk("add_exec_txs", 32'(bus.o_tx_start), 32'h0);
    @(negedge clk);
    chk("add_send_txs", 32'(bus.o_tx_start), 32'h1);
    chk("add_send_txd", 32'(bus.o_tx_data), 32'h08);
    tx_done_pulse();
    chk("add_wtx_txs", 32'(bus.o_tx_start), 32'h0);
    chk("add_wtx_busy", 32'(bus.o_busy), 32'h1);
    finish_tx("add", 8'h08);

    // tx_done while idle is ignored
    tx_done_pulse();
    chk("idle_txdone_busy", 32'(bus.o_busy), 32'h0);

    frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    finish_tx("sub", 8'hFE);
    frame("sra", 8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
    finish_tx("sra", 8'hE0);
    frame("inv", 8'h11, 8'h22, 8'h3F, 8'h00, 1'b1);
    finish_tx("inv", 8'h00);
    chk("inv_A_hold", 32'(bus.o_alu_data_A), 32'h11);
    frame("upper", 8'h11, 8'h22, 8'hE0, 8'h33, 1'b0);
    finish_tx("upper", 8'h33);

    // Dropped bytes while waiting for the transmitter
    frame("drop", 8'h01, 8'h01, 8'h20, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) rx_byte(8'hAA);
    chk("drop3_cnt", 32'(bus.o_drop_cnt), 32'h3);
    chk("drop3_busy", 32'(bus.o_busy), 32'h1);
    chk("drop3_A", 32'(bus.o_alu_data_A), 32'h01);
    for (int i = 0; i < 300; i++) rx_byte(8'h55);
    chk("drop_sat", 32'(bus.o_drop_cnt), 32'hFF);
    chk("drop_sat_busy", 32'(bus.o_busy), 32'h1);
    finish_tx("drop", 8'h02);

    // Incomplete frame waits, then reset mid-frame
    rx_byte(8'h0A);
    rx_byte(8'h0B);
    repeat (10) @(negedge clk);
    chk("partial_busy", 32'(bus.o_busy), 32'h1);
    chk("partial_B", 32'(bus.o_alu_data_B), 32'h0B);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    frame("post", 8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0);
    finish_tx("post", 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
